// File: rtl/line_composer.sv
// Scanline composer: on a line request it latches the line and sprite position,
// captures the map row and the matching sprite ROM row, then streams 848 composed
// 2-bit pixels into the line-buffer bank the display is not reading.
//
// Handshake: line_req is a request pulse that is honoured only while the block is
// IDLE (busy=0) and line_num < V_LINES. A request that arrives while busy is dropped
// and sets the sticky overrun flag. wr_en is a one-way strobe with no back-pressure:
// every cycle wr_en is high, wr_addr/wr_data/wr_bank form one write.
module line_composer #(
  parameter int          H_PIXELS     = 848,
  parameter int          V_LINES      = 480,
  parameter int          SPRITE_W     = 47,
  parameter int          SPRITE_H     = 47,
  parameter logic [1:0]  SPRITE_COLOR = 2'b10
) (
  input  logic                    pixelCLK,
  input  logic                    RESET_N,
  input  logic                    line_req,
  input  logic [8:0]              line_num,
  input  logic [10:0]             sprite_x,
  input  logic [10:0]             sprite_y,
  output logic [8:0]              map_row,
  input  logic [2*H_PIXELS-1:0]   map_data,
  output logic [5:0]              sprite_row_addr,
  input  logic [SPRITE_W-1:0]     sprite_row_data,
  output logic                    wr_en,
  output logic                    wr_bank,
  output logic [9:0]              wr_addr,
  output logic [1:0]              wr_data,
  output logic                    busy,
  output logic                    line_done,
  output logic                    overrun,
  output logic [1:0]              state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [10:0]           sx_q;
  logic [10:0]           sy_q;
  logic [9:0]            x_q;
  logic [2*H_PIXELS-1:0] shadow_q;
  logic [SPRITE_W-1:0]   sprite_bits_q;
  logic                  row_hit_q;

  logic                  accept;
  logic [11:0]           x_ext;
  logic [11:0]           sx_ext;
  logic                  in_cols;
  logic [5:0]            col_off;
  logic [5:0]            bit_idx;
  logic                  sprite_px;
  logic [1:0]            pixel;

  // Requests for lines outside the active area are silently ignored.
  assign accept = (state_q == ST_IDLE) && line_req && (line_num < 9'(V_LINES));

  // State register.
  always_ff @(posedge pixelCLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: one fetch cycle, H_PIXELS write cycles, one done cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_WRITE;
      ST_WRITE: if (x_q == 10'(H_PIXELS - 1)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath: latch request parameters, capture map/sprite rows, step the pixel counter.
  always_ff @(posedge pixelCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      map_row         <= '0;
      sprite_row_addr <= '0;
      sx_q            <= '0;
      sy_q            <= '0;
      x_q             <= '0;
      shadow_q        <= '0;
      sprite_bits_q   <= '0;
      row_hit_q       <= 1'b0;
      wr_bank         <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            map_row         <= line_num;
            sx_q            <= sprite_x;
            sy_q            <= sprite_y;
            // Only the low 6 bits matter; outside the sprite rows the ROM data is unused.
            sprite_row_addr <= line_num[5:0] - sprite_y[5:0];
          end
        end
        ST_FETCH: begin
          shadow_q      <= map_data;
          sprite_bits_q <= sprite_row_data;
          // 12-bit compare so sprite_y near the top of its range cannot wrap into a hit.
          row_hit_q     <= ({3'b000, map_row} >= {1'b0, sy_q}) &&
                           ({3'b000, map_row} <  ({1'b0, sy_q} + 12'(SPRITE_H)));
          x_q           <= '0;
        end
        ST_WRITE: begin
          x_q <= x_q + 10'd1;
        end
        ST_DONE: begin
          wr_bank <= ~wr_bank;
        end
        default: ;
      endcase
    end
  end

  // Sticky overrun: any request seen while a line is in flight is lost.
  always_ff @(posedge pixelCLK or negedge RESET_N) begin
    if (!RESET_N)                            overrun <= 1'b0;
    else if (line_req && state_q != ST_IDLE) overrun <= 1'b1;
  end

  // Pixel composition: sprite bit over map pixel; columns past the line end are never reached.
  always_comb begin
    x_ext     = {2'b00, x_q};
    sx_ext    = {1'b0, sx_q};
    in_cols   = (x_ext >= sx_ext) && (x_ext < (sx_ext + 12'(SPRITE_W)));
    col_off   = x_q[5:0] - sx_q[5:0];
    bit_idx   = 6'(SPRITE_W - 1) - col_off;
    sprite_px = row_hit_q && in_cols && sprite_bits_q[bit_idx];
    pixel     = sprite_px ? SPRITE_COLOR : shadow_q[{x_q, 1'b0} +: 2];
  end

  // Output decode from state; async reset forces IDLE so writes stop immediately.
  always_comb begin
    wr_en     = (state_q == ST_WRITE);
    wr_addr   = wr_en ? x_q : 10'd0;
    wr_data   = wr_en ? pixel : 2'b00;
    busy      = (state_q != ST_IDLE);
    line_done = (state_q == ST_DONE);
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_line_composer.sv
// Bench for line_composer: directed line requests, a per-line expected-write model
// built from the composition rules, and one compare process on every write cycle.
module tb_line_composer;

  localparam int HP = 848;
  localparam int SW = 47;
  localparam int SH = 47;

  logic            pixelCLK = 1'b0;
  logic            RESET_N;
  logic            line_req;
  logic [8:0]      line_num;
  logic [10:0]     sprite_x;
  logic [10:0]     sprite_y;
  logic [8:0]      map_row;
  logic [2*HP-1:0] map_data;
  logic [5:0]      sprite_row_addr;
  logic [SW-1:0]   sprite_row_data;
  logic            wr_en;
  logic            wr_bank;
  logic [9:0]      wr_addr;
  logic [1:0]      wr_data;
  logic            busy;
  logic            line_done;
  logic            overrun;
  logic [1:0]      state_dbg;

  logic [SW-1:0]   rom [0:63];
  logic [2*HP-1:0] map_v;
  logic [12:0]     exp_q[$];
  logic [1:0]      cap [0:HP-1];
  logic            exp_bank;
  int              checks   = 0;
  int              failures = 0;
  int              done_cnt = 0;

  line_composer dut (
    .pixelCLK        (pixelCLK),
    .RESET_N         (RESET_N),
    .line_req        (line_req),
    .line_num        (line_num),
    .sprite_x        (sprite_x),
    .sprite_y        (sprite_y),
    .map_row         (map_row),
    .map_data        (map_data),
    .sprite_row_addr (sprite_row_addr),
    .sprite_row_data (sprite_row_data),
    .wr_en           (wr_en),
    .wr_bank         (wr_bank),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .busy            (busy),
    .line_done       (line_done),
    .overrun         (overrun),
    .state_dbg       (state_dbg)
  );

  // Clock and combinational memories.
  always #5 pixelCLK = ~pixelCLK;
  assign map_data        = map_v;
  assign sprite_row_data = rom[sprite_row_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [2*HP-1:0] fill(input logic [1:0] code);
    logic [2*HP-1:0] m;
    for (int p = 0; p < HP; p++) m[2*p +: 2] = code;
    return m;
  endfunction

  // Model: every pixel of the line as it must be written, in address order.
  task automatic push_line(input int ln, input int sx, input int sy);
    logic [1:0]    code;
    logic [SW-1:0] row;
    for (int x = 0; x < HP; x++) begin
      code = map_v[2*x +: 2];
      if (ln >= sy && ln < sy + SH && x >= sx && x < sx + SW) begin
        row = rom[ln - sy];
        if (row[SW-1-(x-sx)]) code = 2'b10;
      end
      exp_q.push_back({exp_bank, 10'(x), code});
    end
  endtask

  // Scoreboard: every write strobe must match the head of the expected queue.
  always @(negedge pixelCLK) begin
    if (RESET_N) begin
      if (line_done) done_cnt++;
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          chk("wr_unexpected", {19'd0, wr_bank, wr_addr, wr_data}, 32'h1fff);
        end else begin
          chk("wr_pixel", {19'd0, wr_bank, wr_addr, wr_data}, {19'd0, exp_q.pop_front()});
        end
        if (wr_addr < 10'(HP)) cap[wr_addr] = wr_data;
      end
    end
  end

  // Driver: one line request with optional overrun pulse, sprite move, or reset.
  task automatic do_line(input int ln, input int sx, input int sy,
                         input int ovr_at, input int chg_at, input int chg_x, input int rst_at);
    int n;
    int d0;
    bit got;
    @(negedge pixelCLK);
    line_num = 9'(ln); sprite_x = 11'(sx); sprite_y = 11'(sy); line_req = 1'b1;
    push_line(ln, sx, sy);
    d0 = done_cnt;
    @(negedge pixelCLK);
    line_req = 1'b0;
    chk("busy_accept", {31'd0, busy}, 32'd1);
    chk("map_row", {23'd0, map_row}, 32'(ln));
    chk("sprite_row_addr", {26'd0, sprite_row_addr}, 32'((ln - sy) & 63));
    n = 1; got = 0;
    while (n < 2000 && !got) begin
      if (line_done) begin
        chk("done_latency", 32'(n), 32'd850);
        got = 1;
      end else begin
        if (n == ovr_at)     begin line_req = 1'b1; line_num = 9'(ln + 1); end
        if (n == ovr_at + 1) line_req = 1'b0;
        if (n == chg_at)     sprite_x = 11'(chg_x);
        if (n == rst_at) begin
          #2 RESET_N = 1'b0;
          #1;
          chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
          chk("rst_busy", {31'd0, busy}, 32'd0);
          chk("rst_wr_bank", {31'd0, wr_bank}, 32'd0);
          chk("rst_overrun", {31'd0, overrun}, 32'd0);
          exp_q.delete();
          exp_bank = 1'b0;
          repeat (2) @(negedge pixelCLK);
          RESET_N = 1'b1;
          repeat (5) @(negedge pixelCLK);
          chk("rst_no_done", 32'(done_cnt), 32'(d0));
          chk("rst_idle", {31'd0, busy}, 32'd0);
          return;
        end
        @(negedge pixelCLK);
        n++;
      end
    end
    if (!got) chk("done_timeout", 32'(n), 32'd850);
    @(negedge pixelCLK);
    exp_bank = ~exp_bank;
    chk("done_pulse_width", {31'd0, line_done}, 32'd0);
    chk("busy_end", {31'd0, busy}, 32'd0);
    chk("wr_bank_toggle", {31'd0, wr_bank}, {31'd0, exp_bank});
    chk("write_count", 32'(exp_q.size()), 32'd0);
    chk("done_count", 32'(done_cnt), 32'(d0 + 1));
    repeat (3) @(negedge pixelCLK);
    chk("stay_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    RESET_N = 1'b0; line_req = 1'b0; line_num = '0; sprite_x = '0; sprite_y = '0;
    exp_bank = 1'b0;
    map_v = fill(2'b01);
    for (int r = 0; r < 64; r++) rom[r] = 47'h5a5a_c3c3_9696 ^ (47'(r) * 47'h0123_4567);
    rom[0] = 47'h1 << 46;
    rom[2] = '1;
    repeat (3) @(negedge pixelCLK);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_line_done", {31'd0, line_done}, 32'd0);
    chk("reset_overrun", {31'd0, overrun}, 32'd0);
    chk("reset_wr_en", {31'd0, wr_en}, 32'd0);
    chk("reset_wr_bank", {31'd0, wr_bank}, 32'd0);
    chk("reset_wr_addr", {22'd0, wr_addr}, 32'd0);
    chk("reset_wr_data", {30'd0, wr_data}, 32'd0);
    chk("reset_map_row", {23'd0, map_row}, 32'd0);
    chk("reset_sprite_addr", {26'd0, sprite_row_addr}, 32'd0);
    chk("reset_state", {30'd0, state_dbg}, 32'd0);
    RESET_N = 1'b1;
    @(negedge pixelCLK);

    // Sprite off the line: pure map copy.
    map_v = fill(2'b01);
    do_line(10, 0, 200, 0, 0, 0, 0);
    chk("t1_px0", {30'd0, cap[0]}, 32'd1);
    chk("t1_px847", {30'd0, cap[847]}, 32'd1);
    chk("t1_overrun", {31'd0, overrun}, 32'd0);

    // Single sprite pixel at column 100.
    map_v = fill(2'b00);
    do_line(5, 100, 5, 0, 0, 0, 0);
    chk("t2_px99", {30'd0, cap[99]}, 32'd0);
    chk("t2_px100", {30'd0, cap[100]}, 32'd2);
    chk("t2_px101", {30'd0, cap[101]}, 32'd0);

    // Sprite clipped at the right edge.
    map_v = fill(2'b11);
    do_line(12, 830, 10, 0, 0, 0, 0);
    chk("t3_px829", {30'd0, cap[829]}, 32'd3);
    chk("t3_px830", {30'd0, cap[830]}, 32'd2);
    chk("t3_px847", {30'd0, cap[847]}, 32'd2);

    // Varied map with a patterned sprite row mid-line.
    for (int p = 0; p < HP; p++) map_v[2*p +: 2] = 2'(p % 4);
    do_line(20, 400, 10, 0, 0, 0, 0);
    chk("t4_px3", {30'd0, cap[3]}, 32'd3);
    chk("t4_px398", {30'd0, cap[398]}, 32'd2);

    // Out-of-range line request is ignored.
    @(negedge pixelCLK);
    line_num = 9'd480; line_req = 1'b1;
    @(negedge pixelCLK);
    line_req = 1'b0;
    chk("ignore_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge pixelCLK);
    chk("ignore_overrun", {31'd0, overrun}, 32'd0);

    // Overlapping request mid-line.
    map_v = fill(2'b01);
    do_line(30, 0, 200, 400, 0, 0, 0);
    chk("t5_overrun", {31'd0, overrun}, 32'd1);

    // Sprite moved mid-line: latched position applies until the next line.
    map_v = fill(2'b00);
    do_line(7, 100, 5, 0, 50, 300, 0);
    chk("t6a_px100", {30'd0, cap[100]}, 32'd2);
    chk("t6a_px300", {30'd0, cap[300]}, 32'd0);
    do_line(7, 300, 5, 0, 0, 0, 0);
    chk("t6b_px100", {30'd0, cap[100]}, 32'd0);
    chk("t6b_px300", {30'd0, cap[300]}, 32'd2);
    chk("t6_overrun_sticky", {31'd0, overrun}, 32'd1);

    // Reset mid-line, then a normal line.
    map_v = fill(2'b01);
    do_line(40, 0, 200, 0, 0, 0, 300);
    do_line(41, 0, 200, 0, 0, 0, 0);
    chk("t7_bank", {31'd0, wr_bank}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
